mux_n_1_seq: RTL

Sequencer stage that sits directly upstream of the parameterizable N:1 bit multiplexer `mux_n_1`. It accepts an N-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the mux select from 0 to N-1, one bit per accepted beat, so the mux output becomes a serial bit stream with a qualifying valid signal. It supports downstream backpressure and back-to-back words with no idle cycle.

---
 rtl/mux_n_1_seq.sv | 86 ++++++++
 1 files changed

// File: rtl/mux_n_1_seq.sv
// mux_n_1_seq: loads an N-bit word and walks the select of a downstream
// N:1 bit mux from 0 to N-1, producing a serial bit stream (bit 0 first).
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid never depends on ready. in_ready
// depends combinationally on bit_ready on the final bit of a word, so a
// new word can be taken with no idle cycle between words.
module mux_n_1_seq #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  mux_in,
  output logic [SW-1:0] mux_sel,
  output logic          bit_valid,
  input  logic          bit_ready,
  output logic          first,
  output logic          last,
  output logic          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index of the final bit; the select wraps only through this compare,
  // never by natural overflow, so codes above N-1 cannot appear.
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

  state_t state;
  logic   sel_is_last;
  logic   bit_acc;
  logic   in_acc;

  assign sel_is_last = (mux_sel == SEL_LAST);
  assign bit_acc     = bit_valid & bit_ready;
  assign in_acc      = in_valid & in_ready;

  // Status outputs decoded from registered state only; busy exposes the FSM.
  assign bit_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign first     = bit_valid & (mux_sel == '0);
  assign last      = bit_valid & sel_is_last;

  // Ready when empty, or when the final bit leaves this cycle.
  assign in_ready  = (state == IDLE) | (bit_ready & sel_is_last);

  // Sequencer: load a word, step the select on each accepted bit, chain or idle at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mux_in  <= '0;
      mux_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_acc) begin
            mux_in  <= in_data;
            mux_sel <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_acc) begin
            if (!sel_is_last) begin
              mux_sel <= mux_sel + SW'(1);
            end else if (in_acc) begin
              mux_in  <= in_data;
              mux_sel <= '0;
            end else begin
              // Select and word are held so the mux inputs stay quiet while idle.
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
